addsub_serial_nbits: RTL and testbench



---
 rtl/addsub_serial_nbits.sv | 174 +++++++++++++++++
 tb/tb_addsub_serial_nbits.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_nbits.sv
// addsub_serial_nbits: multi-cycle two's-complement adder/subtractor.
// Processes CHUNK bits of a WIDTH-bit A +/- B per clock (N = WIDTH/CHUNK cycles per op).
// A start/busy/done handshake frames each operation. Status flags are registered with the
// result.
//
// Parameters:
//   WIDTH     operand/result width (>= 2)
//   CHUNK     bits processed per cycle (1..WIDTH, must divide WIDTH)
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   start     request, sampled only in IDLE or DONE
//   A, B      operands, sampled on the accepting edge
//   select    0 = A+B, 1 = A-B, sampled on the accepting edge
//   busy      high while the operation runs
//   done      one-cycle pulse, result and flags valid
//   sum       registered result, held until the next completion
//   carry_out carry from the MSB (subtract: 1 = no borrow)
//   overflow  signed overflow
//   zero      sum == 0
// Optional feature: define ADDSUB_STATUS_FLAGS_EN to compute overflow and zero.
// Without it, both outputs are tied to 0.
module addsub_serial_nbits #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = $clog2(N + 1);

    if (WIDTH < 2 || CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : gen_param_err
        $error("addsub_serial_nbits: illegal WIDTH/CHUNK combination");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_sh_q, res_sh_d;
    logic [WIDTH-1:0]  res_next;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_out_q;
    logic              accept;
    logic              last;
    logic [CHUNK:0]    chunk_sum;

    assign accept = start && (state_q == StIdle || state_q == StDone);
    assign last   = (state_q == StRun) && (cnt_q == CntW'(1));

    // Low chunk of the shifted operands plus the running carry; bit CHUNK is the chunk carry.
    assign chunk_sum = {1'b0, a_sh_q[CHUNK-1:0]} + {1'b0, b_sh_q[CHUNK-1:0]}
                     + (CHUNK + 1)'(carry_q);

    // Partial sums enter from the MSB side, so after N chunks the result is in place.
    always_comb begin
        res_next = res_sh_q >> CHUNK;
        res_next[WIDTH-1 -: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cnt_q == CntW'(1)) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

    // Datapath next state
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        if (accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with select.
            a_sh_d  = A;
            b_sh_d  = select ? ~B : B;
            carry_d = select;
            cnt_d   = CntW'(N);
        end else if (state_q == StRun) begin
            a_sh_d   = a_sh_q >> CHUNK;
            b_sh_d   = b_sh_q >> CHUNK;
            res_sh_d = res_next;
            carry_d  = chunk_sum[CHUNK];
            cnt_d    = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            if (last) begin
                sum_q       <= res_next;
                carry_out_q <= chunk_sum[CHUNK];
            end
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;

`ifdef ADDSUB_STATUS_FLAGS_EN
    logic overflow_q;
    logic zero_q;
    logic msb_cin;

    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    assign msb_cin = chunk_sum[CHUNK-1] ^ a_sh_q[CHUNK-1] ^ b_sh_q[CHUNK-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (last) begin
            overflow_q <= msb_cin ^ chunk_sum[CHUNK];
            zero_q     <= (res_next == '0);
        end
    end

    assign overflow = overflow_q;
    assign zero     = zero_q;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_serial_nbits.sv
// Self-checking bench for addsub_serial_nbits: three instances (8/2, 4/4, 16/1),
// expected results queued at issue time and compared when done is seen.
module tb_addsub_serial_nbits;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

`ifdef ADDSUB_STATUS_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        sel = 1'b0;
    logic        start8 = 1'b0, start4 = 1'b0, start16 = 1'b0;

    logic        busy8, done8, cout8, ovf8, zero8;
    logic [7:0]  sum8;
    logic        busy4, done4, cout4, ovf4, zero4;
    logic [3:0]  sum4;
    logic        busy16, done16, cout16, ovf16, zero16;
    logic [15:0] sum16;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    addsub_serial_nbits #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(a_in[7:0]), .B(b_in[7:0]),
        .select(sel), .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8),
        .overflow(ovf8), .zero(zero8)
    );

    addsub_serial_nbits #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .A(a_in[3:0]), .B(b_in[3:0]),
        .select(sel), .busy(busy4), .done(done4), .sum(sum4), .carry_out(cout4),
        .overflow(ovf4), .zero(zero4)
    );

    addsub_serial_nbits #(.WIDTH(16), .CHUNK(1)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .A(a_in), .B(b_in),
        .select(sel), .busy(busy16), .done(done16), .sum(sum16), .carry_out(cout16),
        .overflow(ovf16), .zero(zero16)
    );

    // Reference: modular sum, carry from bit w, overflow from operand/result sign bits.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input int w);
        logic [16:0] mask, am, bm, full;
        res_t r;
        mask   = (17'd1 << w) - 17'd1;
        am     = {1'b0, a} & mask;
        bm     = (s ? {1'b0, ~b} : {1'b0, b}) & mask;
        full   = am + bm + {16'd0, s};
        r.sum  = full[15:0] & mask[15:0];
        r.cout = full[w];
        r.ovf  = FlagsEn && (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
        r.zero = FlagsEn && (r.sum == 16'd0);
        return r;
    endfunction

    function automatic res_t lit(input logic [7:0] s, input logic c, input logic o,
                                 input logic z);
        res_t r;
        r.sum  = {8'h00, s};
        r.cout = c;
        r.ovf  = o & FlagsEn;
        r.zero = z & FlagsEn;
        return r;
    endfunction

    function automatic res_t act(input int which);
        res_t r;
        case (which)
            4:       r = {12'h000, sum4, cout4, ovf4, zero4};
            16:      r = {sum16, cout16, ovf16, zero16};
            default: r = {8'h00, sum8, cout8, ovf8, zero8};
        endcase
        return r;
    endfunction

    function automatic logic get_done(input int which);
        case (which)
            4:       return done4;
            16:      return done16;
            default: return done8;
        endcase
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            4:       start4 = v;
            16:      start16 = v;
            default: start8 = v;
        endcase
    endtask

    // Drive one request; returns 1 ns after the accepting edge with start low.
    task automatic issue(input int which, input logic [15:0] a, input logic [15:0] b,
                         input logic s);
        @(negedge clk);
        a_in = a;
        b_in = b;
        sel  = s;
        set_start(which, 1'b1);
        @(posedge clk);
        #1;
        set_start(which, 1'b0);
    endtask

    // Counts edges until done is seen; k = -1 if the budget expires.
    task automatic wait_done(input int which, input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (get_done(which)) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy8, done8, sum8, cout8, ovf8, zero8} !== 13'd0)
            $display("FAIL reset_values8: got %h want 0",
                     {busy8, done8, sum8, cout8, ovf8, zero8});
        else n_pass++;
        n_checks++;
        if ({busy16, done16, sum16, cout16, ovf16, zero16} !== 21'd0)
            $display("FAIL reset_values16: got %h want 0",
                     {busy16, done16, sum16, cout16, ovf16, zero16});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        res_t te [3];
        res_t e;
        int k;
        ta = '{8'h01, 8'hFF, 8'h7F};
        tb = '{8'h01, 8'h01, 8'h01};
        te = '{lit(8'h02, 0, 0, 0), lit(8'h00, 1, 0, 1), lit(8'h80, 0, 1, 0)};
        for (int i = 0; i < 3; i++) begin
            issue(8, {8'h00, ta[i]}, {8'h00, tb[i]}, 1'b0);
            exp_q.push_back(te[i]);
            n_checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0)
                $display("FAIL add_busy[%0d]: got busy=%b done=%b want 1/0", i, busy8, done8);
            else n_pass++;
            wait_done(8, 10, k);
            n_checks++;
            if (k !== 4) $display("FAIL add_latency[%0d]: got %0d want 4", i, k);
            else n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (act(8) !== e) $display("FAIL add_result[%0d]: got %h want %h", i, act(8), e);
            else n_pass++;
        end
    endtask

    task automatic test_sub();
        logic [7:0] ta [2];
        logic [7:0] tb [2];
        res_t te [2];
        res_t e;
        int k;
        ta = '{8'h03, 8'h0F};
        tb = '{8'h0A, 8'h0F};
        te = '{lit(8'hF9, 0, 0, 0), lit(8'h00, 1, 0, 1)};
        for (int i = 0; i < 2; i++) begin
            issue(8, {8'h00, ta[i]}, {8'h00, tb[i]}, 1'b1);
            exp_q.push_back(te[i]);
            wait_done(8, 10, k);
            n_checks++;
            if (k !== 4) $display("FAIL sub_latency[%0d]: got %0d want 4", i, k);
            else n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (act(8) !== e) $display("FAIL sub_result[%0d]: got %h want %h", i, act(8), e);
            else n_pass++;
        end
    endtask

    // start stays high through RUN with other operands; only the first op may complete.
    task automatic test_start_held();
        res_t e;
        int k;
        @(negedge clk);
        a_in = 16'h0012;
        b_in = 16'h0034;
        sel = 1'b0;
        start8 = 1'b1;
        exp_q.push_back(lit(8'h46, 0, 0, 0));
        @(posedge clk);
        #1;
        a_in = 16'h00AA;
        b_in = 16'h0055;
        sel = 1'b1;
        wait_done(8, 10, k);
        start8 = 1'b0;
        n_checks++;
        if (k !== 4) $display("FAIL held_latency: got %0d want 4", k);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (act(8) !== e) $display("FAIL held_result: got %h want %h", act(8), e);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0)
            $display("FAIL held_idle: got busy=%b done=%b want 0/0", busy8, done8);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        res_t e;
        int k;
        issue(8, 16'h0040, 16'h0040, 1'b0);
        exp_q.push_back(lit(8'h80, 0, 1, 0));
        wait_done(8, 10, k);
        n_checks++;
        if (k !== 4) $display("FAIL b2b_latency0: got %0d want 4", k);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (act(8) !== e) $display("FAIL b2b_result0: got %h want %h", act(8), e);
        else n_pass++;
        // Still in the DONE cycle: request the next op with no bubble.
        a_in = 16'h0080;
        b_in = 16'h0001;
        sel = 1'b1;
        start8 = 1'b1;
        exp_q.push_back(lit(8'h7F, 1, 1, 0));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0)
            $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy8, done8);
        else n_pass++;
        wait_done(8, 10, k);
        n_checks++;
        if (k !== 4) $display("FAIL b2b_latency1: got %0d want 4", k);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (act(8) !== e) $display("FAIL b2b_result1: got %h want %h", act(8), e);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        res_t e;
        int k;
        logic seen;
        issue(8, 16'h0055, 16'h0022, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        start8 = 1'b1;
        a_in = 16'h0001;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy8, done8, sum8, cout8, ovf8, zero8} !== 13'd0)
            $display("FAIL midreset_outputs: got %h want 0",
                     {busy8, done8, sum8, cout8, ovf8, zero8});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        start8 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            seen = seen | done8 | busy8;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL midreset_no_done: got activity=%b want 0", seen);
        else n_pass++;
        issue(8, 16'h0010, 16'h0020, 1'b0);
        exp_q.push_back(lit(8'h30, 0, 0, 0));
        wait_done(8, 10, k);
        n_checks++;
        if (k !== 4) $display("FAIL midreset_latency: got %0d want 4", k);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if (act(8) !== e) $display("FAIL midreset_result: got %h want %h", act(8), e);
        else n_pass++;
    endtask

    task automatic test_sweep(input int which, input int w, input int n);
        res_t e;
        int k;
        logic [15:0] a, b;
        logic s;
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            issue(which, a, b, s);
            exp_q.push_back(model(a, b, s, w));
            wait_done(which, n + 4, k);
            n_checks++;
            if (k !== n) $display("FAIL sweep%0d_latency[%0d]: got %0d want %0d", w, i, k, n);
            else n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if (act(which) !== e)
                $display("FAIL sweep%0d_result[%0d]: a=%h b=%h sel=%b got %h want %h",
                         w, i, a, b, s, act(which), e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_start_held();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep(4, 4, 1);
        test_sweep(16, 16, 16);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
